// File: rtl/mac_chain_controller_if.sv
// rtl/mac_chain_controller_if.sv - coefficient, sample and chain-output handshake bundle
interface mac_chain_controller_if #(
    parameter int COEFFICIENT_WIDTH = 16
);
    logic [COEFFICIENT_WIDTH-1:0] coeff_tdata;
    logic                         coeff_tvalid;
    logic                         coeff_tlast;
    logic                         coeff_tready;
    logic                         s_tvalid;
    logic                         s_tready;
    logic                         m_tvalid;
    logic                         m_tready;

    // Source/sink side: drives coefficients, samples and downstream ready
    modport master (
        output coeff_tdata, coeff_tvalid, coeff_tlast, s_tvalid, m_tready,
        input  coeff_tready, s_tready, m_tvalid
    );

    // Controller side
    modport slave (
        input  coeff_tdata, coeff_tvalid, coeff_tlast, s_tvalid, m_tready,
        output coeff_tready, s_tready, m_tvalid
    );
endinterface

// File: rtl/mac_chain_controller.sv
// rtl/mac_chain_controller.sv - MAC chain sequencer (optional MAC_CHAIN_CONTROLLER_STATS_EN output counter)
module mac_chain_controller #(
    parameter int NUM_TAPS          = 8,
    parameter int COEFFICIENT_WIDTH = 16,
    parameter int LATENCY           = NUM_TAPS + 2
) (
    input  logic                         clock,
    input  logic                         reset,
    mac_chain_controller_if.slave        bus,
    input  logic                         reload_req,
    output logic [COEFFICIENT_WIDTH-1:0] coefficient_out,
    output logic [NUM_TAPS-1:0]          ce_coefficient,
    output logic                         ce_calculate,
    output logic                         chain_reset,
    output logic                         load_error,
    output logic [31:0]                  output_count
);
    localparam int IDX_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int FILL_W = $clog2(LATENCY + 1);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [IDX_W-1:0]  tap_idx;
    logic [FILL_W-1:0] fill_count;
    logic              m_valid;
    logic              coeff_accept;
    logic              at_last_tap;
    logic              end_of_set;
    logic              out_handshake;

    // Coefficients are taken only in LOAD, and not during the chain_reset cycle after reset
    assign bus.coeff_tready = (state == ST_LOAD) && !chain_reset;
    // A sample may enter only when the chain output slot is free or being drained this cycle
    assign bus.s_tready     = (state == ST_RUN) && !chain_reset && (!m_valid || bus.m_tready);
    assign bus.m_tvalid     = m_valid;
    assign ce_calculate     = bus.s_tvalid && bus.s_tready;

    assign coeff_accept  = bus.coeff_tvalid && bus.coeff_tready;
    assign at_last_tap   = (tap_idx == IDX_W'(NUM_TAPS - 1));
    assign end_of_set    = bus.coeff_tlast || at_last_tap;
    assign out_handshake = m_valid && bus.m_tready;

    // Sequencer: coefficient loading, run/drain control, pipeline fill tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_LOAD;
            tap_idx         <= '0;
            fill_count      <= '0;
            m_valid         <= 1'b0;
            load_error      <= 1'b0;
            ce_coefficient  <= '0;
            coefficient_out <= '0;
            chain_reset     <= 1'b1;
        end else begin
            ce_coefficient <= '0;
            chain_reset    <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (coeff_accept) begin
                        coefficient_out <= bus.coeff_tdata;
                        ce_coefficient  <= NUM_TAPS'(1) << tap_idx;
                        if (end_of_set) begin
                            // A set is well formed only when tlast lands exactly on the final tap
                            if (bus.coeff_tlast != at_last_tap)
                                load_error <= 1'b1;
                            state       <= ST_RUN;
                            chain_reset <= 1'b1;
                            fill_count  <= '0;
                            tap_idx     <= '0;
                        end else begin
                            tap_idx <= tap_idx + IDX_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (reload_req)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!m_valid || out_handshake) begin
                        state   <= ST_LOAD;
                        tap_idx <= '0;
                    end
                end
                default: state <= ST_LOAD;
            endcase

            // Output becomes valid once LATENCY samples have been pushed through the chain
            if (ce_calculate) begin
                if (fill_count != FILL_W'(LATENCY))
                    fill_count <= fill_count + FILL_W'(1);
                m_valid <= (fill_count >= FILL_W'(LATENCY - 1));
            end else if (out_handshake) begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef MAC_CHAIN_CONTROLLER_STATS_EN
    // Count chain outputs consumed downstream; wraps naturally at 2^32
    always_ff @(posedge clock) begin
        if (reset)
            output_count <= '0;
        else if (out_handshake)
            output_count <= output_count + 32'd1;
    end
`else
    assign output_count = '0;
`endif

endmodule

// File: tb/tb_mac_chain_controller.sv
// tb/tb_mac_chain_controller.sv - directed self-checking bench for mac_chain_controller
module tb_mac_chain_controller;
    logic        clock;
    logic        reset;
    logic        reload_req;
    logic [15:0] coefficient_out;
    logic [7:0]  ce_coefficient;
    logic        ce_calculate;
    logic        chain_reset;
    logic        load_error;
    logic [31:0] output_count;

    int passed = 0;
    int total  = 0;

    mac_chain_controller_if #(.COEFFICIENT_WIDTH(16)) bus ();

    mac_chain_controller #(
        .NUM_TAPS(8),
        .COEFFICIENT_WIDTH(16),
        .LATENCY(10)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .reload_req(reload_req),
        .coefficient_out(coefficient_out),
        .ce_coefficient(ce_coefficient),
        .ce_calculate(ce_calculate),
        .chain_reset(chain_reset),
        .load_error(load_error),
        .output_count(output_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic load_beat(input logic [15:0] d, input logic last, input logic [7:0] exp_ce);
        bus.coeff_tvalid = 1'b1;
        bus.coeff_tdata  = d;
        bus.coeff_tlast  = last;
        check("coeff_tready_load", 32'(bus.coeff_tready), 32'd1);
        step();
        check("ce_coefficient", 32'(ce_coefficient), 32'(exp_ce));
        check("coefficient_out", 32'(coefficient_out), 32'(d));
    endtask

    initial begin
        reset            = 1'b1;
        reload_req       = 1'b0;
        bus.coeff_tvalid = 1'b0;
        bus.coeff_tdata  = '0;
        bus.coeff_tlast  = 1'b0;
        bus.s_tvalid     = 1'b0;
        bus.m_tready     = 1'b0;
        step(); step(); step();

        // Reset values
        check("rst_s_tready", 32'(bus.s_tready), 32'd0);
        check("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        check("rst_ce_coefficient", 32'(ce_coefficient), 32'd0);
        check("rst_ce_calculate", 32'(ce_calculate), 32'd0);
        check("rst_chain_reset", 32'(chain_reset), 32'd1);
        check("rst_coefficient_out", 32'(coefficient_out), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        check("rst_output_count", output_count, 32'd0);
        check("rst_coeff_tready", 32'(bus.coeff_tready), 32'd0);

        reset = 1'b0;
        #1;
        check("first_cycle_coeff_tready", 32'(bus.coeff_tready), 32'd0);
        step();
        check("load_coeff_tready", 32'(bus.coeff_tready), 32'd1);
        check("load_chain_reset", 32'(chain_reset), 32'd0);

        // Full 8-beat set, tlast on the eighth
        for (int k = 0; k < 8; k++)
            load_beat(16'(k + 1), (k == 7), 8'(1 << k));
        bus.coeff_tvalid = 1'b0;
        bus.coeff_tlast  = 1'b0;
        check("full_chain_reset", 32'(chain_reset), 32'd1);
        check("full_load_error", 32'(load_error), 32'd0);
        check("full_coeff_tready", 32'(bus.coeff_tready), 32'd0);
        check("full_s_tready_in_chain_reset", 32'(bus.s_tready), 32'd0);
        step();
        check("full_chain_reset_pulse_end", 32'(chain_reset), 32'd0);
        check("full_ce_coefficient_end", 32'(ce_coefficient), 32'd0);

        // Prime the pipeline: m_tvalid first rises on the 10th accepted sample
        bus.s_tvalid = 1'b1;
        bus.m_tready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            #1;
            check("prime_ce_calculate", 32'(ce_calculate), 32'd1);
            step();
            check("prime_m_tvalid", 32'(bus.m_tvalid), (i == 10) ? 32'd1 : 32'd0);
        end

        // Backpressure freezes the chain
        bus.m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_s_tready", 32'(bus.s_tready), 32'd0);
            check("bp_ce_calculate", 32'(ce_calculate), 32'd0);
            step();
            check("bp_m_tvalid", 32'(bus.m_tvalid), 32'd1);
        end
        bus.m_tready = 1'b1;
        #1;
        check("resume_s_tready", 32'(bus.s_tready), 32'd1);
        check("resume_ce_calculate", 32'(ce_calculate), 32'd1);
        step();
        check("resume_m_tvalid", 32'(bus.m_tvalid), 32'd1);

        // Reload while output is stalled: DRAIN until the output handshake
        bus.m_tready = 1'b0;
        reload_req   = 1'b1;
        step();
        reload_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drain_coeff_tready", 32'(bus.coeff_tready), 32'd0);
            check("drain_s_tready", 32'(bus.s_tready), 32'd0);
            check("drain_m_tvalid", 32'(bus.m_tvalid), 32'd1);
            step();
        end
        bus.m_tready = 1'b1;
        #1;
        check("drain_ce_calculate", 32'(ce_calculate), 32'd0);
        step();
        check("drain_exit_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        check("drain_exit_coeff_tready", 32'(bus.coeff_tready), 32'd1);
        bus.s_tvalid = 1'b0;

        // Short set: tlast on the third beat
        load_beat(16'hA1, 1'b0, 8'h01);
        load_beat(16'hA2, 1'b0, 8'h02);
        load_beat(16'hA3, 1'b1, 8'h04);
        bus.coeff_tvalid = 1'b0;
        bus.coeff_tlast  = 1'b0;
        check("short_load_error", 32'(load_error), 32'd1);
        check("short_chain_reset", 32'(chain_reset), 32'd1);
        check("short_coeff_tready", 32'(bus.coeff_tready), 32'd0);
        step();
        bus.s_tvalid = 1'b1;
        #1;
        check("short_run_s_tready", 32'(bus.s_tready), 32'd1);
        bus.s_tvalid = 1'b0;

        // Reset mid-run clears the sticky error
        reset = 1'b1;
        step();
        check("midrst_load_error", 32'(load_error), 32'd0);
        check("midrst_chain_reset", 32'(chain_reset), 32'd1);
        check("midrst_s_tready", 32'(bus.s_tready), 32'd0);
        reset = 1'b0;
        step();
        check("midrst_coeff_tready", 32'(bus.coeff_tready), 32'd1);

        // 110 samples with m_tready=1 -> 100 output handshakes
        for (int k = 0; k < 8; k++)
            load_beat(16'(16'h100 + k), (k == 7), 8'(1 << k));
        bus.coeff_tvalid = 1'b0;
        bus.coeff_tlast  = 1'b0;
        step();
        bus.s_tvalid = 1'b1;
        bus.m_tready = 1'b1;
        repeat (110) step();
`ifdef MAC_CHAIN_CONTROLLER_STATS_EN
        check("stats_output_count", output_count, 32'd100);
`else
        check("stats_output_count", output_count, 32'd0);
`endif
        bus.s_tvalid = 1'b0;
        step();
        check("final_m_tvalid", 32'(bus.m_tvalid), 32'd0);
`ifdef MAC_CHAIN_CONTROLLER_STATS_EN
        check("final_output_count", output_count, 32'd101);
`else
        check("final_output_count", output_count, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
